alu_muldiv: RTL and testbench
=============================

# alu_muldiv

Parametrised-width execute-stage ALU for the MIPS datapath. It adds iterative multiply/divide with HI/LO registers, SLTU, signed-overflow detection and a valid/ready handshake to the existing single-cycle op set. It sits between the ID/EX pipeline register and the EX/MEM stage. While a multi-cycle op runs, it stalls the front end by dropping `in_ready`.

## Interface
- `W`, default 32: operand/result width; must be a power of two, at least 8.
- `SHW`, default $clog2(W): shift-amount width.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  op/operands present.
- `in_ready`  out  1  block can accept; combinational, equals (state==IDLE).
- `op`  in  5  operation code (alu_pkg::alu_op_t).
- `A`  in  W  operand A; A[SHW-1:0] is the shift amount for shifts.
- `B`  in  W  operand B.
- `out_valid`  out  1  one-cycle pulse, result on `out`.
- `out`  out  W  registered result.
- `ovf`  out  1  signed overflow of ADD/SUB; valid with `out_valid`, 0 for other ops.

## Operation
- Accept occurs on a rising edge with in_valid && in_ready. Inputs are sampled only on accept.
- Op codes:
  - 0 ADD, 1 SUB: A+B and A−B, wrap modulo 2^W.
  - 2 AND, 3 OR, 4 XOR, 5 NOR.
  - 6 SLL, 7 SRL, 8 SRA: B shifted by A[SHW-1:0].
  - 9 SLT: signed A<B computed by true comparison, correct under overflow.
  - 10 SLTU: unsigned compare.
  - 11 MULT, 12 MULTU, 13 DIV, 14 DIVU.
  - 15 MFHI, 16 MFLO.
  - 17–31: out=0, ovf=0, single-cycle.
- MULT/MULTU write the 2W-bit product to {HI,LO}.
- DIV/DIVU write LO=quotient and HI=remainder. Signed division truncates toward zero; the remainder takes the sign of the dividend.
- Divide by zero: LO = all ones, HI = dividend. For DIV with MIN/−1: LO=MIN, HI=0.
- For mul/div ops, `out` carries the new LO value.
- FSM states:
  - IDLE: a single-cycle op stays in IDLE; a mul/div op goes to BUSY and loads counter=W.
  - BUSY: shift-add multiply or restoring divide on magnitudes; decrement counter each cycle. At 0 go to FIX.
  - FIX: apply sign correction, write HI/LO, go to IDLE.
- HI/LO change only in FIX. MFHI/MFLO issued right after a mul/div return the new values.
- Reset: out=0, out_valid=0, ovf=0, HI=0, LO=0, state=IDLE, counter=0. A reset during BUSY abandons the op with no HI/LO write.

## Timing
- Single-cycle ops: out_valid rises 1 cycle after accept. Back-to-back issue every cycle is allowed.
- MULT/MULTU/DIV/DIVU: out_valid rises W+2 cycles after accept (1 load + W iterations + FIX). in_ready=0 for W+1 cycles.
- out_valid is high for exactly one cycle. There is no output backpressure; the downstream stage must take it.
- in_valid held while in_ready=0 is ignored, not queued.

## Configuration
- `ALU_MULDIV_EN` defined: ops 11–16 behave as above, BUSY/FIX states and HI/LO are present.
- Undefined: ops 11–16 act as ops 17–31 (single-cycle, out=0). No HI/LO or iterative datapath is synthesised, and in_ready is constant 1.

## Structure
- `alu_pkg`: alu_op_t enum (5-bit), state enum (IDLE/BUSY/FIX), and the op-class helper function is_muldiv(op).
- Sub-module `alu_iter_muldiv`: counter, partial-product/remainder registers and sign fix-up. Parametrised on W, with start/done ports. It is instantiated only under ALU_MULDIV_EN.
- Top level holds the combinational op decode, the output registers and the FSM.

## Test plan
- W=32, ADD 0x7FFFFFFF+1 -> out=0x80000000, ovf=1, out_valid 1 cycle after accept. SLT 0x80000000,1 -> 1. SLTU same operands -> 0.
- SRA B=0xF0000000, A=4 -> 0xFF000000. SLL with A=0x25 uses only A[4:0]=5.
- MULT −3 × 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB, out_valid at accept+34, in_ready low 33 cycles. MFHI next -> 0xFFFFFFFF.
- DIV −7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 5/0 -> LO=0xFFFFFFFF, HI=5. DIV 0x80000000/−1 -> LO=0x80000000, HI=0.
- Assert rst_n=0 mid-MULTU -> all outputs 0, HI/LO=0, in_ready=1 after release, and the next ADD completes normally.
- Build without ALU_MULDIV_EN: MULT 2×3 -> out=0 in 1 cycle, in_ready never drops.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared op codes, FSM encodings and op-class helper for the execute-stage ALU.
package alu_pkg;

   typedef enum logic [4:0] {
      OpAdd   = 5'd0,
      OpSub   = 5'd1,
      OpAnd   = 5'd2,
      OpOr    = 5'd3,
      OpXor   = 5'd4,
      OpNor   = 5'd5,
      OpSll   = 5'd6,
      OpSrl   = 5'd7,
      OpSra   = 5'd8,
      OpSlt   = 5'd9,
      OpSltu  = 5'd10,
      OpMult  = 5'd11,
      OpMultu = 5'd12,
      OpDiv   = 5'd13,
      OpDivu  = 5'd14,
      OpMfhi  = 5'd15,
      OpMflo  = 5'd16
   } alu_op_t;

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StBusy = 2'd1;
   localparam logic [1:0] StFix  = 2'd2;

   function automatic logic is_muldiv(alu_op_t op);
      return (op == OpMult) || (op == OpMultu) || (op == OpDiv) || (op == OpDivu);
   endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative shift-add multiply / restoring divide on operand magnitudes, with sign fix-up.
// Results on hi/lo are valid in the cycle after done.
module alu_iter_muldiv
   import alu_pkg::*;
#(
   parameter int unsigned W   = 32,
   parameter int unsigned SHW = $clog2(W)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  alu_op_t      op,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         done,
   output logic [W-1:0] hi,
   output logic [W-1:0] lo
);
   localparam int unsigned CW = SHW + 1;

   logic [CW-1:0]  cnt_q, cnt_d;
   logic [2*W-1:0] p_q, p_d;
   logic [W-1:0]   d_q, d_d, a_q, a_d;
   logic           div_q, div_d, sgn_q, sgn_d, sa_q, sa_d, sb_q, sb_d, bz_q, bz_d;

   logic           op_sgn, op_div, div_ge, neg_q;
   logic [W:0]     mul_sum, div_sh, div_diff;
   logic [2*W-1:0] prod;
   logic [W-1:0]   quo, rem;

   assign op_sgn = (op == OpMult) || (op == OpDiv);
   assign op_div = (op == OpDiv) || (op == OpDivu);

   // p_q holds {accumulator, multiplier} for multiply and {remainder, quotient} for divide
   assign mul_sum  = {1'b0, p_q[2*W-1:W]} + (p_q[0] ? {1'b0, d_q} : '0);
   assign div_sh   = {p_q[2*W-1:W], p_q[W-1]};
   assign div_diff = div_sh - {1'b0, d_q};
   assign div_ge   = (div_sh >= {1'b0, d_q});

   always_comb begin
      cnt_d = cnt_q;
      p_d   = p_q;
      d_d   = d_q;
      a_d   = a_q;
      div_d = div_q;
      sgn_d = sgn_q;
      sa_d  = sa_q;
      sb_d  = sb_q;
      bz_d  = bz_q;
      if (start) begin
         cnt_d = CW'(W);
         p_d   = {{W{1'b0}}, (op_sgn && a[W-1]) ? -a : a};
         d_d   = (op_sgn && b[W-1]) ? -b : b;
         a_d   = a;
         div_d = op_div;
         sgn_d = op_sgn;
         sa_d  = a[W-1];
         sb_d  = b[W-1];
         bz_d  = (b == '0);
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
         p_d   = div_q ? {div_ge ? div_diff[W-1:0] : div_sh[W-1:0], p_q[W-2:0], div_ge}
                       : {mul_sum, p_q[W-1:1]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         p_q   <= '0;
         d_q   <= '0;
         a_q   <= '0;
         div_q <= 1'b0;
         sgn_q <= 1'b0;
         sa_q  <= 1'b0;
         sb_q  <= 1'b0;
         bz_q  <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         p_q   <= p_d;
         d_q   <= d_d;
         a_q   <= a_d;
         div_q <= div_d;
         sgn_q <= sgn_d;
         sa_q  <= sa_d;
         sb_q  <= sb_d;
         bz_q  <= bz_d;
      end
   end

   assign neg_q = sgn_q && (sa_q ^ sb_q);
   assign prod  = neg_q ? -p_q : p_q;
   assign quo   = neg_q ? -p_q[W-1:0] : p_q[W-1:0];
   // Remainder follows the dividend's sign so that division truncates toward zero
   assign rem   = (sgn_q && sa_q) ? -p_q[2*W-1:W] : p_q[2*W-1:W];

   always_comb begin
      if (!div_q) begin
         {hi, lo} = prod;
      end else if (bz_q) begin
         hi = a_q;
         lo = '1;
      end else begin
         hi = rem;
         lo = quo;
      end
   end

   assign done = (cnt_q == CW'(1));

endmodule

// File: rtl/alu_muldiv.sv
// Execute-stage ALU with valid/ready handshake; iterative mul/div and HI/LO are built only
// when ALU_MULDIV_EN is defined, otherwise ops 11-16 return 0 in one cycle.
module alu_muldiv
   import alu_pkg::*;
#(
   parameter int unsigned W   = 32,
   parameter int unsigned SHW = $clog2(W)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  alu_op_t      op,
   input  logic [W-1:0] A,
   input  logic [W-1:0] B,
   output logic         out_valid,
   output logic [W-1:0] out,
   output logic         ovf
);
   logic [W-1:0]   out_q, out_d, alu_res, sum, diff;
   logic           out_valid_q, out_valid_d, ovf_q, ovf_d, alu_ovf;
   logic           accept, single_acc;
   logic [SHW-1:0] shamt;

   assign accept = in_valid && in_ready;
   assign sum    = A + B;
   assign diff   = A - B;
   assign shamt  = A[SHW-1:0];

`ifdef ALU_MULDIV_EN
   logic [1:0]   state_q, state_d;
   logic [W-1:0] hi_q, hi_d, lo_q, lo_d, md_hi, md_lo;
   logic         md_start, md_done;

   assign in_ready   = (state_q == StIdle);
   assign md_start   = accept && is_muldiv(op);
   assign single_acc = accept && !is_muldiv(op);

   alu_iter_muldiv #(
      .W   (W),
      .SHW (SHW)
   ) u_iter (
      .clk   (clk),
      .rst_n (rst_n),
      .start (md_start),
      .op    (op),
      .a     (A),
      .b     (B),
      .done  (md_done),
      .hi    (md_hi),
      .lo    (md_lo)
   );
`else
   assign in_ready   = 1'b1;
   assign single_acc = accept;
`endif

   always_comb begin
      alu_res = '0;
      alu_ovf = 1'b0;
      case (op)
         OpAdd: begin
            alu_res = sum;
            alu_ovf = (A[W-1] == B[W-1]) && (sum[W-1] != A[W-1]);
         end
         OpSub: begin
            alu_res = diff;
            alu_ovf = (A[W-1] != B[W-1]) && (diff[W-1] != A[W-1]);
         end
         OpAnd:  alu_res = A & B;
         OpOr:   alu_res = A | B;
         OpXor:  alu_res = A ^ B;
         OpNor:  alu_res = ~(A | B);
         OpSll:  alu_res = B << shamt;
         OpSrl:  alu_res = B >> shamt;
         OpSra:  alu_res = $signed(B) >>> shamt;
         OpSlt:  alu_res = {{(W-1){1'b0}}, ($signed(A) < $signed(B))};
         OpSltu: alu_res = {{(W-1){1'b0}}, (A < B)};
`ifdef ALU_MULDIV_EN
         OpMfhi: alu_res = hi_q;
         OpMflo: alu_res = lo_q;
`endif
         default: ;
      endcase
   end

   always_comb begin
      out_d       = out_q;
      ovf_d       = ovf_q;
      out_valid_d = 1'b0;
`ifdef ALU_MULDIV_EN
      state_d = state_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      case (state_q)
         StIdle: if (md_start) state_d = StBusy;
         StBusy: if (md_done) state_d = StFix;
         StFix: begin
            hi_d        = md_hi;
            lo_d        = md_lo;
            out_d       = md_lo;
            ovf_d       = 1'b0;
            out_valid_d = 1'b1;
            state_d     = StIdle;
         end
         default: state_d = StIdle;
      endcase
`endif
      if (single_acc) begin
         out_d       = alu_res;
         ovf_d       = alu_ovf;
         out_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q       <= '0;
         out_valid_q <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         ovf_q       <= ovf_d;
      end
   end

`ifdef ALU_MULDIV_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end
`endif

   assign out       = out_q;
   assign out_valid = out_valid_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv (W=32): table-driven single-cycle ops, scoreboarded
// results with cycle-exact arrival, plus mul/div and reset sequences when ALU_MULDIV_EN is set.
module tb_alu_muldiv;
   import alu_pkg::*;

   typedef struct {
      alu_op_t     op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] eo;
      logic        eovf;
   } vec_t;

   typedef struct {
      string       name;
      logic [31:0] eo;
      logic        eovf;
      int          at;
   } exp_t;

   logic        clk, rst_n, in_valid, in_ready, out_valid, ovf;
   alu_op_t     op;
   logic [31:0] A, B, out;

   int   checks = 0;
   int   errors = 0;
   int   edges  = 0;
   exp_t sb[$];
   vec_t vecs[$];

   alu_muldiv #(
      .W (32)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .A         (A),
      .B         (B),
      .out_valid (out_valid),
      .out       (out),
      .ovf       (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) edges <= edges + 1;

   function automatic void check(input string name, input logic [31:0] act,
                                 input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endfunction

   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         if (sb.size() == 0) begin
            check("unexpected out_valid", 32'(out_valid), 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check({e.name, " out"}, out, e.eo);
            check({e.name, " ovf"}, 32'(ovf), 32'(e.eovf));
            check({e.name, " arrival edge"}, 32'(edges), 32'(e.at));
         end
      end
   end

   task automatic issue(input string name, input alu_op_t o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eo, input logic eovf,
                        input int lat);
      exp_t e;
      int   n;
      n = 0;
      while (!in_ready && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      check({name, " in_ready before issue"}, 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      op       = o;
      A        = a;
      B        = b;
      e.name   = name;
      e.eo     = eo;
      e.eovf   = eovf;
      e.at     = edges + 1 + lat;
      sb.push_back(e);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
`ifdef ALU_MULDIV_EN
      int busy;
      localparam int LatMd = 33;
`endif
      rst_n    = 1'b0;
      in_valid = 1'b0;
      op       = OpAdd;
      A        = '0;
      B        = '0;

      vecs.push_back('{OpAdd,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1});
      vecs.push_back('{OpAdd,  32'h00000005, 32'h00000003, 32'h00000008, 1'b0});
      vecs.push_back('{OpAdd,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0});
      vecs.push_back('{OpSub,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1});
      vecs.push_back('{OpSub,  32'h00000003, 32'h00000005, 32'hFFFFFFFE, 1'b0});
      vecs.push_back('{OpAnd,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0});
      vecs.push_back('{OpOr,   32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0});
      vecs.push_back('{OpXor,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0});
      vecs.push_back('{OpNor,  32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F, 1'b0});
      vecs.push_back('{OpSll,  32'h00000025, 32'h00000001, 32'h00000020, 1'b0});
      vecs.push_back('{OpSrl,  32'h00000004, 32'hF0000000, 32'h0F000000, 1'b0});
      vecs.push_back('{OpSra,  32'h00000004, 32'hF0000000, 32'hFF000000, 1'b0});
      vecs.push_back('{OpSlt,  32'h80000000, 32'h00000001, 32'h00000001, 1'b0});
      vecs.push_back('{OpSlt,  32'h00000001, 32'h80000000, 32'h00000000, 1'b0});
      vecs.push_back('{OpSlt,  32'h7FFFFFFF, 32'h80000000, 32'h00000000, 1'b0});
      vecs.push_back('{OpSltu, 32'h80000000, 32'h00000001, 32'h00000000, 1'b0});
      vecs.push_back('{OpSltu, 32'h00000001, 32'h80000000, 32'h00000001, 1'b0});
      vecs.push_back('{alu_op_t'(5'd20), 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b0});
      vecs.push_back('{alu_op_t'(5'd31), 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0});

      #12;
      check("reset out", out, 32'd0);
      check("reset out_valid", 32'(out_valid), 32'd0);
      check("reset ovf", 32'(ovf), 32'd0);
      check("reset in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Back-to-back issue, one op per cycle
      foreach (vecs[i])
         issue($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].eo,
               vecs[i].eovf, 0);
      drain();

`ifdef ALU_MULDIV_EN
      issue("mult -3*7", OpMult, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFEB, 1'b0, LatMd);
      busy = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (in_ready) break;
         busy++;
      end
      check("mult in_ready low cycles", 32'(busy), 32'd33);
      issue("mfhi after mult", OpMfhi, 32'd0, 32'd0, 32'hFFFFFFFF, 1'b0, 0);
      issue("mflo after mult", OpMflo, 32'd0, 32'd0, 32'hFFFFFFEB, 1'b0, 0);

      issue("multu max*max", OpMultu, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, LatMd);
      // An op held on in_valid while busy must be dropped, not queued
      in_valid = 1'b1;
      op       = OpAdd;
      A        = 32'd1;
      B        = 32'd1;
      repeat (5) @(posedge clk);
      #1;
      in_valid = 1'b0;
      issue("mfhi after multu", OpMfhi, 32'd0, 32'd0, 32'hFFFFFFFE, 1'b0, 0);

      issue("div -7/2", OpDiv, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1'b0, LatMd);
      issue("mfhi after div -7/2", OpMfhi, 32'd0, 32'd0, 32'hFFFFFFFF, 1'b0, 0);
      issue("div 7/-2", OpDiv, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, LatMd);
      issue("mfhi after div 7/-2", OpMfhi, 32'd0, 32'd0, 32'h00000001, 1'b0, 0);
      issue("divu 5/0", OpDivu, 32'd5, 32'd0, 32'hFFFFFFFF, 1'b0, LatMd);
      issue("mfhi after divu 5/0", OpMfhi, 32'd0, 32'd0, 32'h00000005, 1'b0, 0);
      issue("div min/-1", OpDiv, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, LatMd);
      issue("mfhi after div min/-1", OpMfhi, 32'd0, 32'd0, 32'h00000000, 1'b0, 0);
      issue("divu 100/7", OpDivu, 32'd100, 32'd7, 32'h0000000E, 1'b0, LatMd);
      issue("mfhi after divu 100/7", OpMfhi, 32'd0, 32'd0, 32'h00000002, 1'b0, 0);
      issue("add ovf before reset", OpAdd, 32'h7FFFFFFF, 32'd1, 32'h80000000, 1'b1, 0);
      drain();

      // Reset in the middle of a MULTU: the op is abandoned, HI/LO are cleared
      in_valid = 1'b1;
      op       = OpMultu;
      A        = 32'd1000;
      B        = 32'd1000;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("mid-reset out", out, 32'd0);
      check("mid-reset out_valid", 32'(out_valid), 32'd0);
      check("mid-reset ovf", 32'(ovf), 32'd0);
      check("mid-reset in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("post-reset in_ready", 32'(in_ready), 32'd1);
      issue("mfhi after reset", OpMfhi, 32'd0, 32'd0, 32'h00000000, 1'b0, 0);
      issue("mflo after reset", OpMflo, 32'd0, 32'd0, 32'h00000000, 1'b0, 0);
      issue("add after reset", OpAdd, 32'd2, 32'd3, 32'h00000005, 1'b0, 0);
`else
      issue("mult 2*3 disabled", OpMult, 32'd2, 32'd3, 32'h00000000, 1'b0, 0);
      check("in_ready after mult", 32'(in_ready), 32'd1);
      issue("divu 5/0 disabled", OpDivu, 32'd5, 32'd0, 32'h00000000, 1'b0, 0);
      check("in_ready after divu", 32'(in_ready), 32'd1);
      issue("mfhi disabled", OpMfhi, 32'd0, 32'd0, 32'h00000000, 1'b0, 0);
      issue("add after disabled ops", OpAdd, 32'd2, 32'd3, 32'h00000005, 1'b0, 0);
`endif
      drain();
      repeat (3) @(posedge clk);
      #1;
      check("scoreboard empty", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
